// File: rtl/multiplier_hd_pkg.sv
// multiplier_hd_pkg: shared digit encodings, FSM states and default sizes for the online multiplier
package multiplier_hd_pkg;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b11;

    localparam int N_DEF     = 20;
    localparam int DELTA_DEF = 3;

    typedef enum logic [1:0] {IDLE, INPUT, FLUSH} state_e;

endpackage

// File: rtl/multiplier_hd_selm.sv
// multiplier_hd_selm: picks the product digit from V truncated to half units (3 integer bits + 1 fraction bit)
// Ports: v_i - truncated residual, signed, LSB weighs 1/2; p_o - selected signed digit
module multiplier_hd_selm
    import multiplier_hd_pkg::*;
(
    input  logic signed [3:0] v_i,
    output logic        [1:0] p_o
);

    // Truncation floors V, so V >= 1/2 <=> v_i >= 1 and V < -1/2 <=> v_i <= -2
    always_comb begin
        p_o = (v_i >= 4'sd1) ? SD_POS : (v_i <= -4'sd2) ? SD_NEG : SD_ZERO;
    end

endmodule

// File: rtl/multiplier_hd.sv
// multiplier_hd: radix-2 MSD-first online signed-digit multiplier with valid/ready digit streams
// Ports: clk, asyn_reset (async, active-low); x_value/y_value operand digits with data_x_vld/data_y_vld
// in and data_x_rdy/data_y_rdy out; p_value product digit with data_out_vld out and data_out_rdy in
module multiplier_hd
    import multiplier_hd_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DELTA = DELTA_DEF,
    parameter int WW    = N + DELTA + 3
) (
    input  logic       clk,
    input  logic       asyn_reset,
    input  logic [1:0] x_value,
    input  logic [1:0] y_value,
    output logic [1:0] p_value,
    input  logic       data_x_vld,
    output logic       data_x_rdy,
    input  logic       data_y_vld,
    output logic       data_y_rdy,
    output logic       data_out_vld,
    input  logic       data_out_rdy
);

    localparam int F  = WW - 3;
    localparam int CW = $clog2(N + DELTA + 1);
    // Weight of digit 1 in the N-fraction-bit operand registers; shifted right by j for digit j+1
    localparam logic signed [N:0]    HALF = (N + 1)'(1) << (N - 1);
    localparam logic signed [WW-1:0] ONE  = WW'(1) << F;

    state_e                 state_q, state_d;
    logic [CW-1:0]          j_q, j_d;
    logic signed [N:0]      x_q, x_d, y_q, y_d, x_new, y_new, unit;
    logic signed [WW-1:0]   w_q, w_d, v, w_new;
    logic [1:0]             p_q, p_d, p_sel, xd, yd;
    logic                   vld_q, vld_d;
    logic                   out_ok, in_st, step, last, emit, load;

    function automatic logic signed [N:0] sgn(input logic [1:0] d, input logic signed [N:0] a);
        return (d == SD_POS) ? a : (d == SD_NEG) ? -a : '0;
    endfunction

    function automatic logic signed [WW-1:0] ext(input logic signed [N:0] a);
        return {{(WW - N - 1){a[N]}}, a};
    endfunction

    multiplier_hd_selm u_selm (
        .v_i (v[WW-1 -: 4]),
        .p_o (p_sel)
    );

    always_comb begin
        out_ok  = !vld_q || data_out_rdy;
        in_st   = state_q == INPUT;
        step    = in_st ? (data_x_vld && data_y_vld && out_ok) : (state_q == FLUSH) && out_ok;
        last    = (state_q == FLUSH) && (j_q == CW'(N + DELTA - 1));
        emit    = j_q >= CW'(DELTA);
        xd      = in_st ? x_value : SD_ZERO;
        yd      = in_st ? y_value : SD_ZERO;
        unit    = HALF >> j_q;
        y_new   = y_q + sgn(yd, unit);
        x_new   = x_q + sgn(xd, unit);
        // X uses the old value, Y the updated one, so each cross term is counted exactly once
        v       = (w_q <<< 1) + ext(sgn(yd, x_q)) + ext(sgn(xd, y_new));
        w_new   = !emit ? v : (p_sel == SD_POS) ? v - ONE : (p_sel == SD_NEG) ? v + ONE : v;
        state_d = (state_q == IDLE) ? INPUT :
                  (step && in_st && j_q == CW'(N - 1)) ? FLUSH :
                  (step && last) ? INPUT : state_q;
        j_d     = step ? (last ? '0 : j_q + 1'b1) : j_q;
        // The final flush step clears the datapath so the next operation starts from zero
        x_d     = step ? (last ? '0 : x_new) : x_q;
        y_d     = step ? (last ? '0 : y_new) : y_q;
        w_d     = step ? (last ? '0 : w_new) : w_q;
        load    = step && emit;
        p_d     = load ? p_sel : p_q;
        vld_d   = load || (vld_q && !data_out_rdy);
    end

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            state_q <= IDLE;
            j_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            p_q     <= SD_ZERO;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            p_q     <= p_d;
            vld_q   <= vld_d;
        end
    end

    assign p_value      = p_q;
    assign data_out_vld = vld_q;
    assign data_x_rdy   = in_st && out_ok && data_y_vld;
    assign data_y_rdy   = in_st && out_ok && data_x_vld;

endmodule

// File: tb/tb_multiplier_hd.sv
// tb_multiplier_hd: randomized bench for multiplier_hd against an arithmetic model of stream timing and product value
module tb_multiplier_hd;

    localparam int N     = 20;
    localparam int DELTA = 3;

    logic       clk = 1'b0;
    logic       asyn_reset = 1'b0;
    logic [1:0] x_value = 2'b00;
    logic [1:0] y_value = 2'b00;
    logic [1:0] p_value;
    logic       data_x_vld = 1'b0;
    logic       data_x_rdy;
    logic       data_y_vld = 1'b0;
    logic       data_y_rdy;
    logic       data_out_vld;
    logic       data_out_rdy = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int ops_checked = 0;
    int op_idx = 0;
    bit rdy_rand = 1'b0;

    logic [1:0] inq_x[$];
    logic [1:0] inq_y[$];
    logic [1:0] outq[$];
    int   pairs = 0;
    int   taken = 0;
    bit   idle = 1'b1;
    bit   pred_vld = 1'b0;
    bit   stall = 1'b0;
    logic [1:0] prev_p = 2'b00;

    multiplier_hd #(.N(N), .DELTA(DELTA)) dut (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .x_value      (x_value),
        .y_value      (y_value),
        .p_value      (p_value),
        .data_x_vld   (data_x_vld),
        .data_x_rdy   (data_x_rdy),
        .data_y_vld   (data_y_vld),
        .data_y_rdy   (data_y_rdy),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy)
    );

    always #5 clk = ~clk;

    function automatic longint dv(input logic [1:0] d);
        return (d == 2'b01) ? 64'sd1 : (d == 2'b11) ? -64'sd1 : 64'sd0;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One finished operation: digits -> scaled integers, then |P - X*Y| <= 2^-N
    task automatic check_op();
        longint xi = 0, yi = 0, pv = 0, err, lim;
        bit nz = 1'b0;
        logic [1:0] d;
        for (int k = 0; k < N; k++) begin
            xi = xi * 2 + dv(inq_x.pop_front());
            yi = yi * 2 + dv(inq_y.pop_front());
            d  = outq.pop_front();
            nz = nz | (d != 2'b00);
            pv = pv * 2 + dv(d);
        end
        lim = longint'(1) << N;
        err = (pv << N) - xi * yi;
        check(err <= lim && err >= -lim, "value", pv << N, xi * yi);
        if (op_idx == 0) check(xi * yi == (longint'(1) << 38), "half_sq", xi * yi, longint'(1) << 38);
        if (op_idx == 1) check(xi * yi == -((lim - 1) * (lim - 1)), "max_neg", xi * yi, -((lim - 1) * (lim - 1)));
        if (op_idx == 2) check(!nz, "zero_digits", longint'(nz), 0);
        op_idx++;
        ops_checked++;
    endtask

    always @(negedge clk) begin
        bit exp_in, ok, acc, load;
        if (!asyn_reset) begin
            check(data_out_vld == 1'b0, "rst_vld", data_out_vld, 0);
            check(p_value == 2'b00, "rst_p", p_value, 0);
            check(!data_x_rdy && !data_y_rdy, "rst_rdy", {data_x_rdy, data_y_rdy}, 0);
            inq_x.delete();
            inq_y.delete();
            outq.delete();
            pairs = 0;
            taken = 0;
            idle = 1'b1;
            pred_vld = 1'b0;
            stall = 1'b0;
        end else begin
            check(data_out_vld == pred_vld, "out_vld", data_out_vld, pred_vld);
            if (stall) check(p_value == prev_p, "hold_p", p_value, prev_p);
            if (data_out_vld) check(p_value != 2'b10, "p_code", p_value, 0);
            // Inputs are accepted only once every digit of all earlier operations has been loaded
            exp_in = !idle && (taken + int'(data_out_vld)) >= (pairs / N) * N;
            ok = !data_out_vld || data_out_rdy;
            check(data_x_rdy == (exp_in && ok && data_y_vld), "x_rdy", data_x_rdy, exp_in && ok && data_y_vld);
            check(data_y_rdy == (exp_in && ok && data_x_vld), "y_rdy", data_y_rdy, exp_in && ok && data_x_vld);
            acc  = exp_in && data_x_vld && data_y_vld && ok;
            load = exp_in ? (acc && (pairs % N) >= DELTA) : (!idle && ok);
            if (acc) begin
                inq_x.push_back(x_value);
                inq_y.push_back(y_value);
                pairs++;
            end
            if (data_out_vld && data_out_rdy) begin
                outq.push_back(p_value);
                taken++;
            end
            stall = data_out_vld && !data_out_rdy;
            prev_p = p_value;
            pred_vld = load || stall;
            idle = 1'b0;
            if (outq.size() >= N && inq_x.size() >= N) check_op();
        end
    end

    always @(posedge clk) begin
        #1 data_out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // mode 0: 1/2 x 1/2, 1: all +1 x all -1, 2: X=0 x random, 3: random x random
    task automatic run_op(input int mode, input bit gaps, input int stop);
        logic [1:0] xs[N];
        logic [1:0] ys[N];
        int i = 0, t = 0;
        for (int k = 0; k < N; k++) begin
            xs[k] = (mode == 0) ? ((k == 0) ? 2'b01 : 2'b00) : (mode == 1) ? 2'b01 :
                    (mode == 2) ? 2'b00 : 2'($urandom_range(0, 3));
            ys[k] = (mode == 0) ? ((k == 0) ? 2'b01 : 2'b00) : (mode == 1) ? 2'b11 : 2'($urandom_range(0, 3));
        end
        while (i < stop && t < 400) begin
            data_x_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            data_y_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            x_value = xs[i];
            y_value = ys[i];
            @(negedge clk);
            if (data_x_vld && data_x_rdy) i++;
            @(posedge clk);
            #1 t++;
        end
        if (i < stop) check(1'b0, "input_stall", i, stop);
        data_x_vld = 1'b0;
        data_y_vld = 1'b0;
    endtask

    task automatic wait_ops(input int n);
        int t = 0;
        while (ops_checked < n && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check(ops_checked >= n, "drain", ops_checked, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 asyn_reset = 1'b1;
        run_op(0, 1'b0, N);
        run_op(1, 1'b0, N);
        run_op(2, 1'b0, N);
        rdy_rand = 1'b1;
        repeat (6) run_op(3, 1'b1, N);
        wait_ops(9);
        run_op(3, 1'b1, 8);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 asyn_reset = 1'b0;
        #1 check(data_out_vld == 1'b0 && p_value == 2'b00, "async_rst", {data_out_vld, p_value}, 0);
        repeat (2) @(posedge clk);
        #2 asyn_reset = 1'b1;
        run_op(3, 1'b1, N);
        run_op(3, 1'b0, N);
        wait_ops(11);
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiplier_hd.md
Name: multiplier_hd

Overview:
- Radix-2 online (MSD-first, digit-serial) signed-digit multiplier.
- Consumes one digit of X and one digit of Y per step, most significant first. Emits one product digit per step after an online delay of DELTA steps.
- Operands and product are fractions in (-1,1) with N digits.
- Sits between digit-serial producers and consumers using valid/ready handshakes on every stream.

Parameters:
- N, 20: digits per operand and per product.
- DELTA, 3: online delay; input steps before the first product digit.
- WW, N+DELTA+3: residual register width (3 integer bits incl. sign, N+DELTA fractional bits).

Ports:
- clk  in  1  rising-edge clock.
- asyn_reset  in  1  reset, asynchronous, active-low.
- x_value  in  2  X digit.
- y_value  in  2  Y digit.
- p_value  out  2  product digit.
- data_x_vld  in  1  x_value valid.
- data_x_rdy  out  1  block accepts an X digit this cycle.
- data_y_vld  in  1  y_value valid.
- data_y_rdy  out  1  block accepts a Y digit this cycle.
- data_out_vld  out  1  p_value valid.
- data_out_rdy  in  1  downstream accepts p_value.

Behaviour:
- Digit encoding, shared by inputs and output:
  - 2'b00 = 0, 2'b01 = +1, 2'b11 = -1.
  - 2'b10 is read as 0 on input and is never produced.
- Value of a digit stream = sum over j=1..N of d_j*2^-j.
- Reset (asyn_reset=0, async) clears all state: state=IDLE, counters=0, X/Y/W=0, p_value=2'b00, data_out_vld=0, data_x_rdy=data_y_rdy=0.
- States:
  - IDLE: after reset; moves to INPUT on the next clock.
  - INPUT: counter j=0..N-1.
  - FLUSH: DELTA steps, j=N..N+DELTA-1, with x=y=0 used internally.
  - After the last FLUSH step the block returns to INPUT with j=0 for the next operation; no reset is needed between operations.
- out_ok = !data_out_vld || data_out_rdy (output register free or draining).
- data_x_rdy = (state==INPUT) && out_ok && data_y_vld; data_y_rdy is symmetric with data_x_vld. Pairs are consumed only jointly.
- A step fires when:
  - INPUT: data_x_vld && data_y_vld && out_ok.
  - FLUSH: out_ok.
  - No step while stalled; all state holds.
- Step j, with digits x, y in {-1,0,1}:
  - V = 2W + (X*y + Ynew*x)*2^-DELTA.
  - Ynew = Y + y*2^-(j+1). Then X += x*2^-(j+1) and Y = Ynew. X and Y are stored as two's-complement fractions (on-the-fly conversion, non-redundant).
  - When j >= DELTA, select p: +1 if V >= 1/2, -1 if V < -1/2, else 0. Then W = V - p.
  - When j < DELTA, W = V and no output is produced.
- Output register:
  - On each step with j >= DELTA, load p_value and set data_out_vld=1.
  - Clear data_out_vld on a handshake (data_out_vld && data_out_rdy) that has no new load.
  - Exactly N product digits are emitted per operation.
- Latency: the first product digit is valid the cycle after the (DELTA+1)-th accepted input pair.
- Accuracy: |sum p_j*2^-j - X*Y| <= 2^-N with |X|,|Y| < 1. Invariant |W| <= 1/2 always; the residual never overflows WW.
- Reset mid-operation aborts the operation; no partial output survives.
- Simultaneous output handshake and new load: the new digit replaces the old one and data_out_vld stays 1.

Decomposition:
- Shared package:
  - digit encodings SD_ZERO/SD_POS/SD_NEG.
  - state enum {IDLE, INPUT, FLUSH}.
  - default N and DELTA.
- One sub-module is natural: multiplier_hd_selm, the combinational digit selector. Input V's integer bits plus 1 fractional bit; output a 2-bit digit.
- Datapath, counters and handshake logic stay in the top.

Test Plan:
- X=0.1000…(=1/2), Y=0.1000…(=1/2), all valid, out_rdy=1 -> 20 output digits whose value equals 1/4 (within 2^-20). First data_out_vld is 1 cycle after the 4th accepted pair.
- X=all +1 (≈1-2^-20), Y=all -1 -> product value ≈ -(1-2^-20)^2 within 2^-20; no digit 2'b10 ever produced.
- X=0 (all 2'b00), Y=random -> all 20 product digits are 2'b00.
- Random X/Y with data_out_rdy toggling 50% and random vld gaps -> no digit lost or duplicated, exactly 20 digits per operation, value within 2^-20 of X*Y. rdy is low whenever out is stalled.
- Two back-to-back operations without reset -> second result correct; the residual from the first does not leak.
- Drive asyn_reset low mid-INPUT -> outputs immediately reset values (vld=0, p=00). Next operation after release is correct.
